bridge_router: RTL and testbench
================================

Name: bridge_router

Overview:
- Parametrised, pipelined address router for the 32-bit APF bridge bus.
- Fans one bridge master port out to NUM_LEAVES leaf ports by inclusive address ranges.
- Adds what a plain decoder lacks: registered decode, fixed-latency pipelined read return, per-leaf byte swap, per-leaf base stripping, a defined unmapped response, and diagnostic counters/flags.
- Sits between the bridge input in the core top-level and the command, dataslot, ROM, DIP and hiscore leaves.

Parameters:
- NUM_LEAVES, 6: number of leaf ports (1..16).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; must be a multiple of 8.
- ADDR_FROM, 0: flattened NUM_LEAVES*ADDR_W vector; slice i is the inclusive low bound of leaf i.
- ADDR_TO, 0: flattened NUM_LEAVES*ADDR_W vector; slice i is the inclusive high bound of leaf i.
- SWAP_MASK, 0: NUM_LEAVES bits; bit i=1 byte-reverses write and read data for leaf i.
- STRIP_MASK, 0: NUM_LEAVES bits; bit i=1 presents leaf_addr as addr minus ADDR_FROM[i].
- RD_LATENCY, 1: fixed leaf read latency in cycles (1..4), counted from the leaf_rd strobe to valid leaf_rd_data.
- UNMAPPED_DATA, 32'hDEADBEEF: read data returned for unmapped addresses.

Ports:
- clk_74a  in  1  bridge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_addr  in  ADDR_W  master address.
- in_wr  in  1  write strobe, single cycle.
- in_wr_data  in  DATA_W  write data.
- in_rd  in  1  read strobe, single cycle.
- in_rd_data  out  DATA_W  read return data.
- in_rd_valid  out  1  one-cycle pulse when in_rd_data is updated.
- leaf_addr  out  ADDR_W  shared leaf address, stripped if the STRIP_MASK bit is set.
- leaf_wr  out  NUM_LEAVES  one-hot write strobes.
- leaf_wr_data  out  DATA_W  shared write data, swapped per SWAP_MASK.
- leaf_rd  out  NUM_LEAVES  one-hot read strobes.
- leaf_rd_data  in  NUM_LEAVES*DATA_W  flattened leaf read data.
- unmapped_count  out  16  saturating count of accesses that hit no leaf.
- overlap_err  out  1  sticky flag: an access matched more than one range.

Behaviour:
- Reset (reset_n=0 at a clk_74a edge):
  - leaf_wr, leaf_rd, in_rd_valid = 0.
  - in_rd_data = 0, leaf_addr = 0, leaf_wr_data = 0.
  - unmapped_count = 0, overlap_err = 0.
  - Read-tracking pipeline flushed. A read in flight when reset asserts never produces in_rd_valid.
- Decode (cycle 0):
  - hit[i] = (in_addr >= ADDR_FROM[i]) && (in_addr <= ADDR_TO[i]), unsigned compare.
  - Selected leaf = lowest index with hit set.
  - If popcount(hit) > 1, set overlap_err (sticky until reset).
- Request stage (cycle 1, registered):
  - leaf_wr[sel] or leaf_rd[sel] pulses for exactly one cycle.
  - leaf_addr and leaf_wr_data are registered in the same cycle and held until the next accepted access.
- Simultaneous in_wr and in_rd: the write is performed and the read is dropped (no leaf_rd, no in_rd_valid).
- Unmapped access (no hit):
  - No leaf strobe.
  - unmapped_count increments, saturating at 16'hFFFF.
  - Reads still return UNMAPPED_DATA with normal latency. Unmapped writes are silently dropped.
- Read return:
  - A shift register of depth RD_LATENCY carries {valid, leaf index, unmapped, swap} for each read.
  - At cycle 1+RD_LATENCY the router samples the selected leaf_rd_data slice (or UNMAPPED_DATA), byte-reverses it if swap is set, and registers it.
  - in_rd_data updates and in_rd_valid pulses at cycle RD_LATENCY+2 after in_rd.
  - in_rd_data holds its value between reads.
- Throughput: one access per cycle, reads and writes mixed. Back-to-back reads to different leaves return in issue order, one per cycle.
- Strip: leaf_addr = in_addr - ADDR_FROM[sel], truncated to ADDR_W. Unmapped accesses leave leaf_addr unchanged.
- Swap: byte k maps to byte DATA_W/8-1-k. Applied to leaf_wr_data on writes and to returned data on reads.

Test Plan:
- Defaults with ranges leaf0=F8000000..F8001FFF and leaf3=00000000..000FFFFF, SWAP_MASK[3]=1: write 0x11223344 to 0x00000010 -> leaf_wr=6'b001000 at cycle 1, leaf_wr_data=0x44332211, leaf_addr=0x10.
- Read 0xF8000004 while leaf0 returns 0xCAFEF00D after 1 cycle -> in_rd_valid at cycle 3, in_rd_data=0xCAFEF00D.
- Reads to 0xF8000000, 0x00000000, 0xF8000000 on consecutive cycles -> three in_rd_valid pulses on cycles 3, 4, 5, each with the correct leaf's data in issue order.
- Read 0x20000000 (unmapped) -> no leaf_rd, in_rd_data=0xDEADBEEF at cycle 3, unmapped_count=1. Then 65540 unmapped writes -> unmapped_count=0xFFFF.
- Overlapping ranges leaf1=0..FF and leaf2=80..1FF, access 0x90 -> leaf1 strobed, overlap_err=1 and it stays set after later clean accesses.
- Issue a read, assert reset_n=0 at cycle 1 for one cycle -> no in_rd_valid afterwards, all outputs at their reset values. Simultaneous in_wr and in_rd -> only leaf_wr pulses.

Source files
------------

// File: rtl/bridge_router.sv
// rtl/bridge_router.sv - pipelined address router fanning the bridge bus out to leaf ports
// Registered decode, fixed-latency read return, per-leaf swap/strip, unmapped and overlap diagnostics.
module bridge_router #(
  parameter int                           NUM_LEAVES    = 6,
  parameter int                           ADDR_W        = 32,
  parameter int                           DATA_W        = 32,
  parameter logic [NUM_LEAVES*ADDR_W-1:0] ADDR_FROM     = '0,
  parameter logic [NUM_LEAVES*ADDR_W-1:0] ADDR_TO       = '0,
  parameter logic [NUM_LEAVES-1:0]        SWAP_MASK     = '0,
  parameter logic [NUM_LEAVES-1:0]        STRIP_MASK    = '0,
  parameter int                           RD_LATENCY    = 1,
  parameter logic [DATA_W-1:0]            UNMAPPED_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                         clk_74a,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic                         in_wr,
  input  logic [DATA_W-1:0]            in_wr_data,
  input  logic                         in_rd,
  output logic [DATA_W-1:0]            in_rd_data,
  output logic                         in_rd_valid,
  output logic [ADDR_W-1:0]            leaf_addr,
  output logic [NUM_LEAVES-1:0]        leaf_wr,
  output logic [DATA_W-1:0]            leaf_wr_data,
  output logic [NUM_LEAVES-1:0]        leaf_rd,
  input  logic [NUM_LEAVES*DATA_W-1:0] leaf_rd_data,
  output logic [15:0]                  unmapped_count,
  output logic                         overlap_err
);

  localparam int IDX_W  = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
  localparam int NBYTES = DATA_W / 8;

  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NBYTES; k++) begin
      r[8*k +: 8] = d[8*(NBYTES-1-k) +: 8];
    end
    return r;
  endfunction

  logic [NUM_LEAVES-1:0] w_hit;
  logic [NUM_LEAVES-1:0] w_onehot;
  logic [IDX_W-1:0]      w_sel;
  logic [ADDR_W-1:0]     w_base;
  logic                  w_swap;
  logic                  w_strip;
  logic                  w_any;
  logic                  w_multi;
  logic                  w_is_rd;

  always_comb begin
    w_hit   = '0;
    w_sel   = '0;
    w_base  = '0;
    w_swap  = 1'b0;
    w_strip = 1'b0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      w_hit[i] = (in_addr >= ADDR_FROM[i*ADDR_W +: ADDR_W]) &&
                 (in_addr <= ADDR_TO[i*ADDR_W +: ADDR_W]);
    end
    // Walk downwards so the lowest matching index is the one left standing.
    for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel   = IDX_W'(i);
        w_base  = ADDR_FROM[i*ADDR_W +: ADDR_W];
        w_swap  = SWAP_MASK[i];
        w_strip = STRIP_MASK[i];
      end
    end
  end

  assign w_any    = |w_hit;
  assign w_onehot = w_hit & (~w_hit + NUM_LEAVES'(1));
  assign w_multi  = (w_hit & (w_hit - NUM_LEAVES'(1))) != '0;
  assign w_is_rd  = in_rd & ~in_wr;

  logic [NUM_LEAVES-1:0] r_leaf_wr;
  logic [NUM_LEAVES-1:0] r_leaf_rd;
  logic [ADDR_W-1:0]     r_leaf_addr;
  logic [DATA_W-1:0]     r_leaf_wr_data;
  logic [15:0]           r_unmapped_count;
  logic                  r_overlap_err;

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      r_leaf_wr        <= '0;
      r_leaf_rd        <= '0;
      r_leaf_addr      <= '0;
      r_leaf_wr_data   <= '0;
      r_unmapped_count <= '0;
      r_overlap_err    <= 1'b0;
    end else begin
      r_leaf_wr <= '0;
      r_leaf_rd <= '0;
      if (in_wr || in_rd) begin
        if (w_multi) begin
          r_overlap_err <= 1'b1;
        end
        if (w_any) begin
          r_leaf_addr <= w_strip ? (in_addr - w_base) : in_addr;
          if (in_wr) begin
            r_leaf_wr      <= w_onehot;
            r_leaf_wr_data <= w_swap ? byte_swap(in_wr_data) : in_wr_data;
          end else begin
            r_leaf_rd <= w_onehot;
          end
        end else if (r_unmapped_count != 16'hFFFF) begin
          r_unmapped_count <= r_unmapped_count + 16'd1;
        end
      end
    end
  end

  // Stage 0 lines up with the leaf_rd strobe; stage RD_LATENCY with valid leaf data.
  logic             r_tv   [0:RD_LATENCY];
  logic [IDX_W-1:0] r_tidx [0:RD_LATENCY];
  logic             r_tum  [0:RD_LATENCY];
  logic             r_tsw  [0:RD_LATENCY];

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      for (int j = 0; j <= RD_LATENCY; j++) begin
        r_tv[j]   <= 1'b0;
        r_tidx[j] <= '0;
        r_tum[j]  <= 1'b0;
        r_tsw[j]  <= 1'b0;
      end
    end else begin
      r_tv[0]   <= w_is_rd;
      r_tidx[0] <= w_sel;
      r_tum[0]  <= ~w_any;
      r_tsw[0]  <= w_swap & w_any;
      for (int j = 1; j <= RD_LATENCY; j++) begin
        r_tv[j]   <= r_tv[j-1];
        r_tidx[j] <= r_tidx[j-1];
        r_tum[j]  <= r_tum[j-1];
        r_tsw[j]  <= r_tsw[j-1];
      end
    end
  end

  logic [DATA_W-1:0] w_leaf_data;
  logic [DATA_W-1:0] w_ret_data;

  always_comb begin
    w_leaf_data = '0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      if (r_tidx[RD_LATENCY] == IDX_W'(i)) begin
        w_leaf_data = leaf_rd_data[i*DATA_W +: DATA_W];
      end
    end
    w_ret_data = r_tum[RD_LATENCY] ? UNMAPPED_DATA : w_leaf_data;
    if (r_tsw[RD_LATENCY]) begin
      w_ret_data = byte_swap(w_ret_data);
    end
  end

  logic [DATA_W-1:0] r_in_rd_data;
  logic              r_in_rd_valid;

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      r_in_rd_data  <= '0;
      r_in_rd_valid <= 1'b0;
    end else begin
      r_in_rd_valid <= r_tv[RD_LATENCY];
      if (r_tv[RD_LATENCY]) begin
        r_in_rd_data <= w_ret_data;
      end
    end
  end

  assign in_rd_data     = r_in_rd_data;
  assign in_rd_valid    = r_in_rd_valid;
  assign leaf_addr      = r_leaf_addr;
  assign leaf_wr        = r_leaf_wr;
  assign leaf_wr_data   = r_leaf_wr_data;
  assign leaf_rd        = r_leaf_rd;
  assign unmapped_count = r_unmapped_count;
  assign overlap_err    = r_overlap_err;

endmodule

// File: tb/tb_bridge_router.sv
// tb/tb_bridge_router.sv - scoreboard bench for bridge_router
// Leaf models answer RD_LATENCY cycles after their strobe; request and read queues hold expectations.
module tb_bridge_router;

  localparam int NL  = 6;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int RDL = 1;
  localparam logic [NL*AW-1:0] FROM = {32'h40000000, 32'h30000000, 32'h00000000,
                                       32'h10000080, 32'h10000000, 32'hF8000000};
  localparam logic [NL*AW-1:0] TO   = {32'h40000FFF, 32'h3000FFFF, 32'h000FFFFF,
                                       32'h100001FF, 32'h100000FF, 32'hF8001FFF};
  localparam logic [NL-1:0] SWAP  = 6'b011000;
  localparam logic [NL-1:0] STRIP = 6'b010011;

  logic              clk_74a;
  logic              reset_n;
  logic [AW-1:0]     in_addr;
  logic              in_wr;
  logic [DW-1:0]     in_wr_data;
  logic              in_rd;
  logic [DW-1:0]     in_rd_data;
  logic              in_rd_valid;
  logic [AW-1:0]     leaf_addr;
  logic [NL-1:0]     leaf_wr;
  logic [DW-1:0]     leaf_wr_data;
  logic [NL-1:0]     leaf_rd;
  logic [NL*DW-1:0]  leaf_rd_data;
  logic [15:0]       unmapped_count;
  logic              overlap_err;

  bridge_router #(
    .NUM_LEAVES(NL), .ADDR_W(AW), .DATA_W(DW),
    .ADDR_FROM(FROM), .ADDR_TO(TO), .SWAP_MASK(SWAP), .STRIP_MASK(STRIP),
    .RD_LATENCY(RDL), .UNMAPPED_DATA(32'hDEADBEEF)
  ) dut (
    .clk_74a(clk_74a), .reset_n(reset_n),
    .in_addr(in_addr), .in_wr(in_wr), .in_wr_data(in_wr_data), .in_rd(in_rd),
    .in_rd_data(in_rd_data), .in_rd_valid(in_rd_valid),
    .leaf_addr(leaf_addr), .leaf_wr(leaf_wr), .leaf_wr_data(leaf_wr_data),
    .leaf_rd(leaf_rd), .leaf_rd_data(leaf_rd_data),
    .unmapped_count(unmapped_count), .overlap_err(overlap_err)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    logic [5:0]  wr;
    logic [5:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_addr;
    bit          chk_wdata;
  } req_exp_t;

  rd_exp_t  rd_q[$];
  req_exp_t req_q[$];

  logic [31:0] m_from [NL] = '{32'hF8000000, 32'h10000000, 32'h10000080,
                               32'h00000000, 32'h30000000, 32'h40000000};
  logic [31:0] m_to   [NL] = '{32'hF8001FFF, 32'h100000FF, 32'h100001FF,
                               32'h000FFFFF, 32'h3000FFFF, 32'h40000FFF};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int m_unmapped = 0;
  bit m_overlap  = 0;
  bit mon_en     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] leaf_val(input int i, input logic [31:0] a);
    logic [31:0] b [NL];
    b = '{32'hCAFEF00D, 32'h11110000, 32'h22220000, 32'hA5A50303, 32'h0BB0C00C, 32'h5A5A6006};
    return b[i] ^ (a & 32'h00000FF0);
  endfunction

  initial clk_74a = 1'b0;
  always #5 clk_74a = ~clk_74a;
  always @(posedge clk_74a) cyc <= cyc + 1;

  always @(posedge clk_74a) begin
    for (int i = 0; i < NL; i++) begin
      leaf_rd_data[i*DW +: DW] <= leaf_rd[i] ? leaf_val(i, leaf_addr) : (32'h0BADBAD0 ^ 32'(i));
    end
  end

  rd_exp_t  mon_e;
  req_exp_t mon_r;

  always @(negedge clk_74a) begin
    if (mon_en) begin
      if (in_rd_valid) begin
        n_valid++;
        if (rd_q.size() == 0) begin
          check_eq("stray_rd_valid", 64'(in_rd_valid), 64'd0);
        end else begin
          mon_e = rd_q.pop_front();
          check_eq("rd_cycle", 64'(cyc), 64'(mon_e.cyc));
          check_eq("rd_data", 64'(in_rd_data), 64'(mon_e.data));
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        mon_e = rd_q.pop_front();
        check_eq("rd_missing", 64'(in_rd_valid), 64'd1);
      end
      if (req_q.size() > 0 && req_q[0].cyc == cyc) begin
        mon_r = req_q.pop_front();
        check_eq("leaf_wr", 64'(leaf_wr), 64'(mon_r.wr));
        check_eq("leaf_rd", 64'(leaf_rd), 64'(mon_r.rd));
        if (mon_r.chk_addr) check_eq("leaf_addr", 64'(leaf_addr), 64'(mon_r.addr));
        if (mon_r.chk_wdata) check_eq("leaf_wr_data", 64'(leaf_wr_data), 64'(mon_r.wdata));
      end else if ((leaf_wr | leaf_rd) != '0) begin
        check_eq("stray_strobe", 64'({leaf_wr, leaf_rd}), 64'd0);
      end
    end
  end

  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wd, input bit push_rd);
    int          sel;
    int          hits;
    logic [31:0] la;
    logic [31:0] v;
    req_exp_t    r;
    rd_exp_t     e;
    @(posedge clk_74a);
    #1;
    in_wr = wr; in_rd = rd; in_addr = addr; in_wr_data = wd;
    sel = -1; hits = 0;
    for (int i = 0; i < NL; i++) begin
      if (addr >= m_from[i] && addr <= m_to[i]) begin
        hits++;
        if (sel < 0) sel = i;
      end
    end
    if (hits > 1) m_overlap = 1;
    r.cyc = cyc + 1; r.wr = '0; r.rd = '0; r.addr = '0; r.wdata = '0;
    r.chk_addr = 0; r.chk_wdata = 0;
    la = addr;
    if (sel < 0) begin
      if (m_unmapped < 65535) m_unmapped++;
    end else begin
      la = STRIP[sel] ? addr - m_from[sel] : addr;
      r.addr = la; r.chk_addr = 1;
      if (wr) begin
        r.wr[sel] = 1'b1;
        r.wdata = SWAP[sel] ? bswap(wd) : wd;
        r.chk_wdata = 1;
      end else begin
        r.rd[sel] = 1'b1;
      end
    end
    req_q.push_back(r);
    if (rd && !wr && push_rd) begin
      v = (sel < 0) ? 32'hDEADBEEF : leaf_val(sel, la);
      if (sel >= 0 && SWAP[sel]) v = bswap(v);
      e.cyc = cyc + 2 + RDL;
      e.data = v;
      rd_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_74a);
      #1;
      in_wr = 0; in_rd = 0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_leaf_wr"}, 64'(leaf_wr), 64'd0);
    check_eq({tag, "_leaf_rd"}, 64'(leaf_rd), 64'd0);
    check_eq({tag, "_rd_valid"}, 64'(in_rd_valid), 64'd0);
    check_eq({tag, "_rd_data"}, 64'(in_rd_data), 64'd0);
    check_eq({tag, "_leaf_addr"}, 64'(leaf_addr), 64'd0);
    check_eq({tag, "_leaf_wr_data"}, 64'(leaf_wr_data), 64'd0);
    check_eq({tag, "_unmapped"}, 64'(unmapped_count), 64'd0);
    check_eq({tag, "_overlap"}, 64'(overlap_err), 64'd0);
  endtask

  int valid_snap;

  initial begin
    reset_n = 0; in_wr = 0; in_rd = 0; in_addr = '0; in_wr_data = '0;
    repeat (3) @(posedge clk_74a);
    @(negedge clk_74a);
    check_reset_state("reset");
    @(posedge clk_74a);
    #1;
    reset_n = 1;
    mon_en = 1;

    access(1, 0, 32'h00000010, 32'h11223344, 1);
    idle(3);
    access(0, 1, 32'hF8000004, '0, 1);
    idle(4);
    access(0, 1, 32'hF8000000, '0, 1);
    access(0, 1, 32'h00000000, '0, 1);
    access(0, 1, 32'hF8000000, '0, 1);
    idle(5);
    access(0, 1, 32'h20000000, '0, 1);
    idle(4);
    check_eq("unmapped_one", 64'(unmapped_count), 64'd1);

    access(0, 1, 32'h10000040, '0, 1);
    access(0, 1, 32'h30000123, '0, 1);
    access(1, 0, 32'h30000456, 32'hA1B2C3D4, 1);
    access(0, 1, 32'h10000100, '0, 1);
    access(1, 0, 32'h40000010, 32'h01020304, 1);
    access(1, 0, 32'h50000000, 32'hFFFFFFFF, 1);
    access(0, 1, 32'h000FFFFF, '0, 1);
    access(0, 1, 32'h00100000, '0, 1);
    access(0, 1, 32'hF7FFFFFF, '0, 1);
    access(0, 1, 32'hF8001FFF, '0, 1);
    access(0, 1, 32'hF8002000, '0, 1);
    access(0, 1, 32'h40000FFF, '0, 1);
    idle(5);
    check_eq("unmapped_mid", 64'(unmapped_count), 64'(m_unmapped));
    check_eq("overlap_clean", 64'(overlap_err), 64'(m_overlap));

    access(0, 1, 32'h10000090, '0, 1);
    idle(4);
    check_eq("overlap_set", 64'(overlap_err), 64'd1);
    access(1, 0, 32'h00000020, 32'h55667788, 1);
    access(0, 1, 32'h30000000, '0, 1);
    idle(4);
    check_eq("overlap_sticky", 64'(overlap_err), 64'(m_overlap));

    valid_snap = n_valid;
    access(1, 1, 32'h00000030, 32'h99AABBCC, 1);
    idle(5);
    check_eq("wr_rd_no_valid", 64'(n_valid), 64'(valid_snap));

    for (int i = 0; i < 65540; i++) begin
      access(1, 0, 32'h20000000 + 32'(i), 32'(i), 1);
    end
    idle(3);
    check_eq("unmapped_model", 64'(unmapped_count), 64'(m_unmapped));
    check_eq("unmapped_sat", 64'(unmapped_count), 64'hFFFF);

    valid_snap = n_valid;
    access(0, 1, 32'hF8000000, '0, 0);
    @(posedge clk_74a);
    #1;
    in_rd = 0;
    reset_n = 0;
    @(posedge clk_74a);
    #1;
    reset_n = 1;
    m_unmapped = 0;
    m_overlap = 0;
    @(negedge clk_74a);
    check_reset_state("midreset");
    idle(5);
    check_eq("flushed_read", 64'(n_valid), 64'(valid_snap));

    access(0, 1, 32'h40000020, '0, 1);
    access(0, 1, 32'h00000040, '0, 1);
    idle(6);
    check_eq("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check_eq("req_q_drained", 64'(req_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
